// File: rtl/sd_dat_pkg.sv
// Shared definitions for the card-side SD DAT responder.
// Contents: FSM state encoding, CRC16 polynomial, CRC status tokens and
// the data word width.
package sd_dat_pkg;

   localparam int          WORD_W     = 32;
   localparam logic [15:0] CRC16_POLY = 16'h1021;   // x^16 + x^12 + x^5 + 1
   localparam logic [2:0]  STAT_OK    = 3'b010;
   localparam logic [2:0]  STAT_ERR   = 3'b101;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RX_DATA,
      S_RX_CRC,
      S_RX_END,
      S_NWR_WAIT,
      S_STAT,
      S_BUSY,
      S_BUSY_END,    // single "1" cycle that closes the busy phase
      S_RD_WAIT,
      S_TX_START,
      S_TX_DATA,
      S_TX_CRC,
      S_TX_END
   } state_e;

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16 (CCITT, initial value 0), one bit per clock, MSB first.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   clear        : zero the register (wins over enable)
//   enable       : fold bit_in into the CRC this cycle
//   bit_in       : serial data bit
//   crc[15:0]    : current CRC register
module sd_crc16
   import sd_dat_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        enable,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = crc_q[15] ^ bit_in;
      crc_d = crc_q;
      if (clear)
         crc_d = '0;
      else if (enable)
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) crc_q <= '0;
      else       crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/sd_dat_card.sv
// Card-side SD DAT responder, 1-bit bus mode.
// Host write: receive block(s) of 32-bit words, check CRC16, return the CRC
// status token after NWR cycles, then hold busy. Host read: serialise words
// from tx_data into blocks with CRC16, optionally repeating until stop.
// Ports:
//   clock, reset          : SD clock (rising edge), async active-high reset
//   dat_in                : DAT as driven by the host
//   dat_out, dat_oe       : card DAT value and drive enable
//   blockSize, multiblock : words per block (0 = 16), repeat reads
//   start_read, stop      : read start pulse, multiblock stop pulse
//   tx_data/valid/pop     : word source for reads
//   rx_data/push, rx_full : word sink for writes, sink backpressure on busy
//   crc_err, underrun     : sticky error flags
//   busy                  : FSM not idle
module sd_dat_card
   import sd_dat_pkg::*;
#(
   parameter int NAC         = 2,
   parameter int NWR         = 2,
   parameter int BUSY_CYCLES = 8
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              dat_in,
   output logic              dat_out,
   output logic              dat_oe,
   input  logic [3:0]        blockSize,
   input  logic              multiblock,
   input  logic              start_read,
   input  logic              stop,
   input  logic [WORD_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_pop,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_push,
   input  logic              rx_full,
   output logic              crc_err,
   output logic              underrun,
   output logic              busy
);

   localparam logic [4:0] NAC_LAST  = 5'(NAC - 1);
   localparam logic [4:0] NWR_LAST  = 5'(NWR - 1);
   localparam logic [4:0] BUSY_LAST = 5'(BUSY_CYCLES - 1);

   state_e            state_q, state_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [4:0]        word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] sr_q, sr_d;          // rx/tx word, rx CRC, status token
   logic [3:0]        blk_q, blk_d;
   logic              mb_q, mb_d;
   logic              stop_seen_q, stop_seen_d;
   logic [WORD_W-1:0] rx_data_q, rx_data_d;
   logic              rx_push_q, rx_push_d;
   logic              crc_err_q, crc_err_d;
   logic              underrun_q, underrun_d;

   logic              crc_clr, crc_en, crc_bit, tx_pop_c;
   logic [15:0]       crc_w;
   logic [4:0]        last_word;

   // blockSize 0 wraps to 15 here, i.e. 16 words
   assign last_word = {1'b0, blk_q - 4'd1};

   sd_crc16 u_crc (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clr),
      .enable (crc_en),
      .bit_in (crc_bit),
      .crc    (crc_w)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         sr_q        <= '0;
         blk_q       <= '0;
         mb_q        <= 1'b0;
         stop_seen_q <= 1'b0;
         rx_data_q   <= '0;
         rx_push_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         sr_q        <= sr_d;
         blk_q       <= blk_d;
         mb_q        <= mb_d;
         stop_seen_q <= stop_seen_d;
         rx_data_q   <= rx_data_d;
         rx_push_q   <= rx_push_d;
         crc_err_q   <= crc_err_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q + 5'd1;
      word_cnt_d  = word_cnt_q;
      sr_d        = sr_q;
      blk_d       = blk_q;
      mb_d        = mb_q;
      stop_seen_d = stop_seen_q;
      rx_data_d   = rx_data_q;
      rx_push_d   = 1'b0;
      crc_err_d   = crc_err_q;
      underrun_d  = underrun_q;
      crc_clr     = 1'b0;
      crc_en      = 1'b0;
      crc_bit     = dat_in;
      tx_pop_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            // write start bit has priority; start_read in the same cycle is lost
            if (!dat_in) begin
               state_d = S_RX_DATA;
               crc_clr = 1'b1;
               blk_d   = blockSize;
               mb_d    = multiblock;
            end else if (start_read) begin
               state_d = S_RD_WAIT;
            end
         end
         S_RX_DATA: begin
            crc_en = 1'b1;
            sr_d   = {sr_q[WORD_W-2:0], dat_in};
            if (bit_cnt_q == 5'd31) begin
               rx_data_d  = {sr_q[WORD_W-2:0], dat_in};
               rx_push_d  = 1'b1;
               word_cnt_d = word_cnt_q + 5'd1;
               if (word_cnt_q == last_word) begin
                  state_d   = S_RX_CRC;
                  bit_cnt_d = '0;
               end
            end
         end
         S_RX_CRC: begin
            sr_d = {sr_q[WORD_W-2:0], dat_in};
            if (bit_cnt_q == 5'd15) begin
               state_d   = S_RX_END;
               bit_cnt_d = '0;
            end
         end
         S_RX_END: begin
            // token is parked MSB-aligned and shifted out during STAT
            if (sr_q[15:0] == crc_w && dat_in)
               sr_d = {1'b0, STAT_OK, 1'b1, 27'd0};
            else begin
               sr_d      = {1'b0, STAT_ERR, 1'b1, 27'd0};
               crc_err_d = 1'b1;
            end
            state_d   = S_NWR_WAIT;
            bit_cnt_d = '0;
         end
         S_NWR_WAIT: begin
            if (bit_cnt_q == NWR_LAST) begin
               state_d   = S_STAT;
               bit_cnt_d = '0;
            end
         end
         S_STAT: begin
            sr_d = {sr_q[WORD_W-2:0], 1'b0};
            if (bit_cnt_q == 5'd4) begin
               state_d   = S_BUSY;
               bit_cnt_d = '0;
            end
         end
         S_BUSY: begin
            // saturate so a long rx_full stall cannot re-arm the minimum
            if (bit_cnt_q == 5'd31) bit_cnt_d = bit_cnt_q;
            if (bit_cnt_q >= BUSY_LAST && !rx_full) state_d = S_BUSY_END;
         end
         S_BUSY_END: state_d = S_IDLE;
         S_RD_WAIT: begin
            if (bit_cnt_q == 5'd31) bit_cnt_d = bit_cnt_q;
            if (stop)
               state_d = S_IDLE;
            else if (bit_cnt_q >= NAC_LAST && tx_valid)
               state_d = S_TX_START;
         end
         S_TX_START: begin
            sr_d        = tx_data;
            tx_pop_c    = 1'b1;
            crc_clr     = 1'b1;
            bit_cnt_d   = '0;
            word_cnt_d  = '0;
            blk_d       = blockSize;
            mb_d        = multiblock;
            stop_seen_d = stop;
            state_d     = S_TX_DATA;
         end
         S_TX_DATA: begin
            crc_en      = 1'b1;
            crc_bit     = sr_q[WORD_W-1];
            sr_d        = {sr_q[WORD_W-2:0], 1'b1};
            stop_seen_d = stop_seen_q | stop;
            if (bit_cnt_q == 5'd31) begin
               if (word_cnt_q == last_word) begin
                  state_d   = S_TX_CRC;
                  bit_cnt_d = '0;
               end else begin
                  word_cnt_d = word_cnt_q + 5'd1;
                  if (tx_valid) begin
                     sr_d     = tx_data;
                     tx_pop_c = 1'b1;
                  end else begin
                     sr_d       = '1;
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         S_TX_CRC: begin
            stop_seen_d = stop_seen_q | stop;
            if (bit_cnt_q == 5'd15) begin
               state_d   = S_TX_END;
               bit_cnt_d = '0;
            end
         end
         S_TX_END: begin
            bit_cnt_d = '0;
            if (mb_q && !stop_seen_q && !stop) state_d = S_RD_WAIT;
            else                               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dat_oe  = 1'b0;
      dat_out = 1'b1;
      case (state_q)
         S_STAT:     begin dat_oe = 1'b1; dat_out = sr_q[WORD_W-1]; end
         S_BUSY:     begin dat_oe = 1'b1; dat_out = 1'b0; end
         S_BUSY_END: begin dat_oe = 1'b1; dat_out = 1'b1; end
         S_TX_START: begin dat_oe = 1'b1; dat_out = 1'b0; end
         S_TX_DATA:  begin dat_oe = 1'b1; dat_out = sr_q[WORD_W-1]; end
         // CRC register is frozen here, so it is read out directly
         S_TX_CRC:   begin dat_oe = 1'b1; dat_out = crc_w[4'd15 - bit_cnt_q[3:0]]; end
         S_TX_END:   begin dat_oe = 1'b1; dat_out = 1'b1; end
         default:    begin dat_oe = 1'b0; dat_out = 1'b1; end
      endcase
   end

   assign tx_pop   = tx_pop_c;
   assign rx_data  = rx_data_q;
   assign rx_push  = rx_push_q;
   assign crc_err  = crc_err_q;
   assign underrun = underrun_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: doc/sd_dat_card.md
Name: sd_dat_card

Overview:
Card-side model and responder for the SD DAT line, in 1-bit bus mode. It is the far end of the host DAT block.
- Host write: receives data blocks, checks CRC16, returns the CRC status token, then signals busy.
- Host read: serialises 32-bit words from a word source into blocks with CRC16.
- It is instantiated opposite the host DAT engine in the DAT-level benches and the top-level SD bench. One DAT bit is exchanged per `clock` cycle.

Parameters:
NAC, 2, idle cycles from the `start_read` pulse to the first start bit, and between consecutive read blocks.
NWR, 2, cycles from the received end bit to the CRC status start bit.
BUSY_CYCLES, 8, minimum busy (DAT low) cycles after the CRC status token.

Ports:
clock  input  1  bit clock (SD clock domain); all logic is on the rising edge.
reset  input  1  asynchronous, active-high reset.
dat_in  input  1  DAT line as driven by the host.
dat_out  output  1  DAT value driven by the card.
dat_oe  output  1  1 = card drives DAT.
blockSize  input  4  block length in 32-bit words; 0 means 16 words.
multiblock  input  1  1 = read blocks repeat until `stop`.
start_read  input  1  one-cycle pulse that starts a read transfer.
stop  input  1  one-cycle pulse that ends a multiblock read after the current block.
tx_data  input  32  next word to transmit, MSB first.
tx_valid  input  1  `tx_data` is valid.
tx_pop  output  1  one-cycle pulse: `tx_data` consumed.
rx_data  output  32  received word, MSB first.
rx_push  output  1  one-cycle pulse: `rx_data` valid.
rx_full  input  1  receive sink is full; busy is extended while it is high.
crc_err  output  1  sticky: a write block failed its CRC check; cleared by reset.
underrun  output  1  sticky: `tx_valid` was low at a word boundary; cleared by reset.
busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset values: `dat_out` = 1, `dat_oe` = 0, `tx_pop` = 0, `rx_push` = 0, `rx_data` = 0, `crc_err` = 0, `underrun` = 0, `busy` = 0, FSM in IDLE, all counters 0.
- Reset asserted mid-operation: immediate return to IDLE, DAT released, CRC cleared.
- CRC16: CCITT polynomial x^16+x^12+x^5+1, initial value 0. Computed over data bits only; the start bit and end bit are excluded. CRC is sent and compared MSB first.
- Counters: bit counter 5 bits, wrapping at 31; word counter 5 bits, compared against the effective block length (1..16).
- FSM states and transitions:
  - IDLE
    - `dat_oe` = 0.
    - `dat_in` == 0 → RX_DATA; CRC cleared; the start bit itself is not shifted.
    - `start_read` → RD_WAIT.
    - Both in the same cycle: the write start bit wins and `start_read` is dropped.
  - RX_DATA
    - Shift `dat_in` in, MSB first.
    - After each 32nd bit: `rx_data` updated and `rx_push` pulsed in the next cycle.
    - After the final word → RX_CRC.
  - RX_CRC: 16 cycles capturing the received CRC → RX_END.
  - RX_END: sample the end bit.
    - Status = 010 if the CRC matched and the end bit == 1.
    - Otherwise status = 101 and `crc_err` set.
    - → NWR_WAIT.
  - NWR_WAIT: NWR cycles with the line released → STAT.
  - STAT: `dat_oe` = 1 for 5 cycles, `dat_out` = 0, s2, s1, s0, 1 → BUSY.
  - BUSY
    - `dat_oe` = 1, `dat_out` = 0 for at least BUSY_CYCLES cycles.
    - Continues while `rx_full` = 1.
    - Then one cycle of `dat_out` = 1 → IDLE.
  - RD_WAIT
    - Line released.
    - Waits NAC cycles and `tx_valid` = 1 → TX_START.
    - `stop` here → IDLE.
  - TX_START: `dat_oe` = 1, `dat_out` = 0, `tx_data` latched, `tx_pop` pulsed → TX_DATA.
  - TX_DATA
    - Shift the latched word out, MSB first.
    - At each later word boundary: if `tx_valid`, latch the word and pulse `tx_pop`; else send 0xFFFFFFFF and set `underrun`.
    - After the final word → TX_CRC.
  - TX_CRC: 16 CRC bits → TX_END.
  - TX_END: `dat_out` = 1 for one cycle.
    - If `multiblock` and no `stop` seen during the block → RD_WAIT.
    - Otherwise → IDLE.
- `stop` while not in a read state is ignored.
- `blockSize` and `multiblock` are sampled on block entry (RX_DATA or TX_START) and held for that block.
- Host/card contention is not detected; the bench checks that the two output enables are never both 1.

Decomposition:
- Package `sd_dat_pkg`:
  - FSM state enum.
  - CRC16 polynomial constant 16'h1021.
  - CRC status codes 3'b010 (OK) and 3'b101 (CRC error).
  - Word width 32.
- Sub-module `sd_crc16`, a serial CRC16 with ports `clock`, `reset`, `clear`, `enable`, `bit_in`, `crc[15:0]`. One instance is shared by the RX and TX paths.

Test Plan:
- Write, good CRC (`blockSize` = 2, host sends 0xC0000003, 0xC000E000 plus a golden CRC) → two `rx_push` pulses carrying those words; exactly 2 cycles after the end bit, DAT shows 0,0,1,0,1; then 8 busy cycles; `crc_err` stays 0.
- Write with one CRC bit flipped → status token 0,1,0,1,1; `crc_err` = 1; line released after busy.
- Write with `rx_full` held high for 20 cycles at the end → busy lasts 20 cycles instead of 8, then DAT = 1 and release.
- Single read (`blockSize` = 1, `tx_data` = 0xA5A5A5A5, `tx_valid` = 1) → `start_read` pulse, 2 released cycles, start bit 0, 32 data bits, CRC matching the golden model, end bit 1; one `tx_pop` pulse.
- Multiblock read (`blockSize` = 1), `stop` during the second block → exactly two blocks with NAC = 2 gap cycles between them, then IDLE.
- Underrun and reset: `blockSize` = 2 with `tx_valid` dropped before word 2 → second word 0xFFFFFFFF and `underrun` = 1. Reset asserted mid-block → `dat_oe` = 0 asynchronously and all outputs at reset values.
